car_button_conditioner: RTL

Upstream input stage for the crossroad display top. Conditions raw board pushbuttons into clean event strobes. Six asynchronous, bouncing button inputs are synchronised, debounced, and converted into one-cycle pulses. The pulses drive the four car-arrival inputs, the status-change input and the car-to-cross input.

---
 rtl/car_button_conditioner_if.sv | 40 ++++
 rtl/car_button_conditioner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/car_button_conditioner_if.sv
// -----------------------------------------------------------------------------
// car_button_conditioner_if
//
// Purpose:
//   Groups the pushbutton signals that travel between the raw board inputs and
//   the crossroad display logic. The conditioner consumes the raw levels and
//   produces the debounced level plus a one-clock press strobe per button.
//
// Parameters:
//   NUM_BTN   number of button channels (bit 0=a1, 1=a2, 2=b1, 3=b2,
//             4=status change, 5=car-to-cross-if-green)
//
// Signals:
//   btn_raw    raw pushbutton levels, asynchronous to clk, active-high
//   btn_level  debounced level per button
//   btn_pulse  one-clock strobe per accepted press
//
// Modports:
//   master  drives btn_raw, observes btn_level / btn_pulse (board / bench side)
//   slave   the conditioner itself
// -----------------------------------------------------------------------------
interface car_button_conditioner_if #(
   parameter int NUM_BTN = 6
);
   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_pulse;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_pulse
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_pulse
   );
endinterface

// File: rtl/car_button_conditioner.sv
// -----------------------------------------------------------------------------
// car_button_conditioner
//
// Purpose:
//   Input stage of the crossroad display. Each raw, bouncing pushbutton is
//   passed through a 2-flop synchroniser and a per-channel debounce FSM. An
//   accepted press raises the debounced level and emits a single-cycle strobe
//   in the same cycle; releases only lower the level. Channels are fully
//   independent copies of the same logic.
//
// Parameters:
//   NUM_BTN               number of button channels
//   DEBOUNCE_CYCLES       consecutive stable synced samples needed to accept a
//                         level change (>= 1)
//   REPEAT_DELAY_CYCLES   press-to-first-repeat hold time (auto-repeat build)
//   REPEAT_PERIOD_CYCLES  interval between later repeats (auto-repeat build)
//
// Ports:
//   clk     system clock
//   rst     asynchronous, active-low reset (0 = reset); release is already
//           synchronised to clk outside this block
//   btn_if  slave side of car_button_conditioner_if
//             btn_raw   (in)  raw levels, asynchronous, active-high
//             btn_level (out) registered debounced level
//             btn_pulse (out) registered one-clock press strobe
//
// Build option:
//   CAR_BTN_AUTOREPEAT_EN  when defined, holding a button in the pressed state
//                          emits a repeat strobe after REPEAT_DELAY_CYCLES and
//                          then every REPEAT_PERIOD_CYCLES. When undefined no
//                          repeat logic exists and each press strobes once.
//
// Timing (raw rises before clock edge 0 and stays high):
//   edge 0 -> s1, edge 1 -> s2, edge 2 -> PRESS_WAIT with cnt=1,
//   edge DEBOUNCE_CYCLES+2 -> PRESSED, btn_pulse and btn_level registered high.
//   Releases mirror this: btn_level falls DEBOUNCE_CYCLES+2 edges after raw.
// -----------------------------------------------------------------------------
module car_button_conditioner #(
   parameter int NUM_BTN              = 6,
   parameter int DEBOUNCE_CYCLES      = 1_000_000,
   parameter int REPEAT_DELAY_CYCLES  = 50_000_000,
   parameter int REPEAT_PERIOD_CYCLES = 20_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   car_button_conditioner_if.slave  btn_if
);

   // Elaboration-time sanity checks on the configuration.
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("car_button_conditioner: DEBOUNCE_CYCLES must be >= 1");
   end
   if (REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_bad_repeat
      $error("car_button_conditioner: repeat delay/period must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   // The counter never needs to exceed DEBOUNCE_CYCLES: each WAIT state is
   // left on reaching it, so no wrap protection is needed.
   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

`ifdef CAR_BTN_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                            REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
   localparam int                RPT_W           = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0]  RPT_ONE         = RPT_W'(1);
   // Compare against "last value before the hit" so the strobe is registered
   // exactly REPEAT_DELAY_CYCLES / REPEAT_PERIOD_CYCLES edges after the
   // previous one.
   localparam logic [RPT_W-1:0]  RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [RPT_W-1:0]  RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD_CYCLES - 1);
`endif

   logic [NUM_BTN-1:0] level_vec;
   logic [NUM_BTN-1:0] pulse_vec;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch

      logic             s1;
      logic             s2;
      state_t           state_q;
      state_t           state_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             pulse_q;
      logic             pulse_d;
      logic             level_q;
      logic             level_d;

`ifdef CAR_BTN_AUTOREPEAT_EN
      logic [RPT_W-1:0] rpt_q;
      logic [RPT_W-1:0] rpt_d;
      // Cleared until the first repeat; afterwards the period applies.
      logic             rpt_armed_q;
      logic             rpt_armed_d;
      logic             rpt_hit;

      assign rpt_hit = rpt_armed_q ? (rpt_q == RPT_PERIOD_LAST)
                                   : (rpt_q == RPT_DELAY_LAST);
`endif

      // ---- synchroniser stage: raw -> s1 -> s2 ----
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
         end else begin
            s1 <= btn_if.btn_raw[i];
            s2 <= s1;
         end
      end

      // ---- debounce FSM state / output registers ----
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pulse_q     <= 1'b0;
            level_q     <= 1'b0;
`ifdef CAR_BTN_AUTOREPEAT_EN
            rpt_q       <= '0;
            rpt_armed_q <= 1'b0;
`endif
         end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
            level_q     <= level_d;
`ifdef CAR_BTN_AUTOREPEAT_EN
            rpt_q       <= rpt_d;
            rpt_armed_q <= rpt_armed_d;
`endif
         end
      end

      always_comb begin
         state_d     = state_q;
         cnt_d       = cnt_q;
         pulse_d     = 1'b0;
         level_d     = level_q;
`ifdef CAR_BTN_AUTOREPEAT_EN
         rpt_d       = rpt_q;
         rpt_armed_d = rpt_armed_q;
`endif
         case (state_q)
            IDLE: begin
               if (s2) begin
                  state_d = PRESS_WAIT;
                  cnt_d   = CNT_ONE;
               end
            end

            PRESS_WAIT: begin
               if (!s2) begin
                  // Too short to be a press: drop it silently.
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
                  pulse_d = 1'b1;
                  level_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end

            PRESSED: begin
               if (!s2) begin
                  // Repeat counter holds its value while the release is
                  // being qualified, so a release bounce resumes the cadence.
                  state_d = RELEASE_WAIT;
                  cnt_d   = CNT_ONE;
               end
`ifdef CAR_BTN_AUTOREPEAT_EN
               else if (rpt_hit) begin
                  pulse_d     = 1'b1;
                  rpt_d       = '0;
                  rpt_armed_d = 1'b1;
               end else begin
                  rpt_d = rpt_q + RPT_ONE;
               end
`endif
            end

            RELEASE_WAIT: begin
               if (s2) begin
                  // Release bounce: back to pressed with no new strobe.
                  state_d = PRESSED;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_d     = IDLE;
                  cnt_d       = '0;
                  level_d     = 1'b0;
`ifdef CAR_BTN_AUTOREPEAT_EN
                  rpt_d       = '0;
                  rpt_armed_d = 1'b0;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end

            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               level_d = 1'b0;
            end
         endcase
      end

      assign level_vec[i] = level_q;
      assign pulse_vec[i] = pulse_q;
   end

   assign btn_if.btn_level = level_vec;
   assign btn_if.btn_pulse = pulse_vec;

endmodule
